// File: rtl/activation_sequencer.sv
// rtl/activation_sequencer.sv - job-level row sequencer around the 8-lane activation unit
module activation_sequencer #(
    parameter int ROW_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [2:0]           cfg_mode,
    input  logic                 cfg_float,
    input  logic [ROW_CNT_W-1:0] cfg_rows,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_error,
    input  logic                 in_valid,
    input  logic [63:0]          in_data,
    output logic                 in_ready,
    output logic [63:0]          act_inputs,
    output logic [2:0]           act_mode,
    output logic                 act_float,
    output logic                 act_input_valid,
    input  logic                 act_output_valid,
    input  logic [63:0]          act_outputs,
    output logic                 out_valid,
    output logic [63:0]          out_data,
    input  logic                 out_ready,
    output logic [ROW_CNT_W-1:0] rows_done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [2:0]           mode_q;
    logic                 float_q;
    logic [ROW_CNT_W-1:0] rows_q;
    logic [ROW_CNT_W-1:0] in_cnt;
    logic                 accept;
    logic                 pop;
    logic                 load;
    logic                 job_start;

    // A start pulse is only meaningful while idle; elsewhere it is dropped.
    assign job_start = (state == IDLE) && start;

    // The output stage can take a new row if it is empty or draining this cycle.
    assign in_ready = (state == RUN) && (in_cnt < rows_q) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign load     = accept && act_output_valid;

    assign act_inputs      = (state == RUN) ? in_data : 64'd0;
    assign act_mode        = mode_q;
    assign act_float       = float_q;
    assign act_input_valid = accept;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Next-state logic for the job FSM.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && !cfg_mode[2]) begin
                    state_next = (cfg_rows == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && (in_cnt + 1'b1 == rows_q)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid || out_ready) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any job without a done pulse.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Job configuration is captured on every start and held for the whole job.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            mode_q    <= 3'd0;
            float_q   <= 1'b0;
            rows_q    <= '0;
            cfg_error <= 1'b0;
        end else if (job_start) begin
            mode_q    <= cfg_mode;
            float_q   <= cfg_float;
            rows_q    <= cfg_rows;
            cfg_error <= cfg_mode[2];
        end
    end

    // Accepted-row and delivered-row counters, cleared at each start.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            in_cnt    <= '0;
            rows_done <= '0;
        end else if (job_start) begin
            in_cnt    <= '0;
            rows_done <= '0;
        end else begin
            if (accept) begin
                in_cnt <= in_cnt + 1'b1;
            end
            if (pop) begin
                rows_done <= rows_done + 1'b1;
            end
        end
    end

    // One-entry output register; a simultaneous pop and load keeps it full.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            out_valid <= 1'b0;
            out_data  <= 64'd0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= act_outputs;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_activation_sequencer.sv
// tb/tb_activation_sequencer.sv - directed self-checking bench for activation_sequencer
module tb_activation_sequencer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [2:0]  cfg_mode;
    logic        cfg_float;
    logic [7:0]  cfg_rows;
    logic        busy;
    logic        done;
    logic        cfg_error;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic [63:0] act_inputs;
    logic [2:0]  act_mode;
    logic        act_float;
    logic        act_input_valid;
    logic        act_output_valid;
    logic [63:0] act_outputs;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;
    logic [7:0]  rows_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    activation_sequencer #(.ROW_CNT_W(8)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .cfg_mode(cfg_mode),
        .cfg_float(cfg_float), .cfg_rows(cfg_rows), .busy(busy), .done(done),
        .cfg_error(cfg_error), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .act_inputs(act_inputs), .act_mode(act_mode),
        .act_float(act_float), .act_input_valid(act_input_valid),
        .act_output_valid(act_output_valid), .act_outputs(act_outputs),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .rows_done(rows_done)
    );

    // Stand-in for the combinational activation unit.
    function automatic logic [7:0] act_lane(input logic [7:0] x, input logic [2:0] m, input logic f);
        logic neg;
        logic pos;
        neg = x[7];
        pos = !x[7] && (x[6:0] != 7'd0);
        case (m)
            3'b000:  return neg ? 8'h00 : x;
            3'b001:  return pos ? 8'hFF : 8'h00;
            3'b011:  return neg ? (f ? {1'b1, 1'b0, x[6:1]} : {x[7], x[7:1]}) : x;
            default: return x;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            act_outputs[i*8 +: 8] = act_lane(act_inputs[i*8 +: 8], act_mode, act_float);
        end
    end
    assign act_output_valid = act_input_valid;

    logic [63:0] d5 [4] = '{64'h0001_8081_7FFF_40C0, 64'h1111_1111_1111_1111,
                            64'h9999_9999_9999_9999, 64'h0100_0100_0100_0100};
    logic [63:0] e5 [4] = '{64'h00FF_0000_FF00_FF00, 64'hFFFF_FFFF_FFFF_FFFF,
                            64'h0000_0000_0000_0000, 64'hFF00_FF00_FF00_FF00};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cfg_error"}, cfg_error, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_act_inputs"}, act_inputs, 0);
        chk({tag, "_act_mode"}, act_mode, 0);
        chk({tag, "_act_float"}, act_float, 0);
        chk({tag, "_act_input_valid"}, act_input_valid, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_rows_done"}, rows_done, 0);
    endtask

    int  sent;
    int  recv;
    bit  seen_done;

    initial begin
        n_rst = 1'b0; start = 1'b0; cfg_mode = 3'd0; cfg_float = 1'b0; cfg_rows = 8'd0;
        in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b0;
        tick(); tick();
        chk_all_zero("reset");
        n_rst = 1'b1;

        // Relu, fixed, three rows, downstream always ready.
        start = 1'b1; cfg_mode = 3'b000; cfg_float = 1'b0; cfg_rows = 8'd3;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 64'h807F_01FF_0010_9005; out_ready = 1'b1;
        #1;
        chk("t1_busy", busy, 1);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_act_input_valid", act_input_valid, 1);
        chk("t1_act_inputs", act_inputs, 64'h807F_01FF_0010_9005);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t1_out_valid", out_valid, 1);
            chk("t1_out_data", out_data, 64'h007F_0100_0010_0005);
            chk("t1_rows_done", rows_done, 64'(k));
        end
        chk("t1_drain_in_ready", in_ready, 0);
        in_valid = 1'b0;
        tick();
        chk("t1_done", done, 1);
        chk("t1_rows_done_end", rows_done, 3);
        tick();
        chk("t1_done_clear", done, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_rows_hold", rows_done, 3);

        // Leaky relu, fixed, two rows, downstream stalls for four cycles.
        start = 1'b1; cfg_mode = 3'b011; cfg_rows = 8'd2;
        tick();
        start = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h10F0_0000_0000_0080;
        #1;
        chk("t2_in_ready_first", in_ready, 1);
        tick();
        in_data = 64'h7F00_0000_0000_00FE;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_stall_in_ready", in_ready, 0);
            chk("t2_stall_out_data", out_data, 64'h10F8_0000_0000_00C0);
            chk("t2_stall_rows_done", rows_done, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("t2_release_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t2_row2_data", out_data, 64'h7F00_0000_0000_00FF);
        chk("t2_row2_rows_done", rows_done, 1);
        tick();
        chk("t2_done", done, 1);
        chk("t2_rows_done_end", rows_done, 2);
        tick();

        // Illegal mode, then a legal identity job clears the flag.
        start = 1'b1; cfg_mode = 3'b101; cfg_rows = 8'd2; in_valid = 1'b1;
        in_data = 64'h0123_4567_89AB_CDEF;
        tick();
        start = 1'b0;
        chk("t3_cfg_error", cfg_error, 1);
        chk("t3_busy", busy, 0);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_act_mode", act_mode, 3'b101);
        start = 1'b1; cfg_mode = 3'b010; cfg_rows = 8'd1;
        tick();
        start = 1'b0;
        chk("t3_cfg_error_clear", cfg_error, 0);
        chk("t3_busy_run", busy, 1);
        tick();
        in_valid = 1'b0;
        chk("t3_identity", out_data, 64'h0123_4567_89AB_CDEF);
        tick();
        chk("t3_done", done, 1);
        chk("t3_rows_done", rows_done, 1);
        tick();

        // Zero-row job goes straight to DONE.
        start = 1'b1; cfg_mode = 3'b000; cfg_rows = 8'd0; in_valid = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_busy", busy, 1);
        chk("t4_done", done, 1);
        chk("t4_in_ready", in_ready, 0);
        chk("t4_rows_done", rows_done, 0);
        tick();
        in_valid = 1'b0;
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_done", done, 0);

        // Threshold, float, four rows, upstream and downstream toggling out of phase.
        start = 1'b1; cfg_mode = 3'b001; cfg_float = 1'b1; cfg_rows = 8'd4;
        tick();
        start = 1'b0;
        sent = 0; recv = 0; seen_done = 1'b0;
        for (int c = 0; c < 60 && !seen_done; c++) begin
            in_valid  = (c % 2 == 0) && (sent < 4);
            in_data   = (sent < 4) ? d5[sent] : 64'd0;
            out_ready = (c % 2 == 1);
            #1;
            if (done) seen_done = 1'b1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                if (recv < 4) chk("t5_out_data", out_data, e5[recv]);
                else chk("t5_extra_row", 64'(recv), 4);
                recv++;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("t5_seen_done", seen_done, 1);
        chk("t5_recv", 64'(recv), 4);
        chk("t5_sent", 64'(sent), 4);
        chk("t5_rows_done", rows_done, 4);
        chk("t5_idle", busy, 0);

        // Reset mid-job, then a clean identity job.
        start = 1'b1; cfg_mode = 3'b000; cfg_float = 1'b0; cfg_rows = 8'd5;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 64'h0000_0000_0000_0011; out_ready = 1'b1;
        tick();
        tick();
        chk("t6_rows_before", rows_done, 1);
        n_rst = 1'b0;
        tick();
        chk_all_zero("t6_abort");
        n_rst = 1'b1; in_valid = 1'b0;
        tick();
        chk("t6_no_done", done, 0);
        start = 1'b1; cfg_mode = 3'b010; cfg_rows = 8'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 64'hA5A5_5A5A_0F0F_F0F0;
        tick();
        in_valid = 1'b0;
        chk("t6_new_out", out_data, 64'hA5A5_5A5A_0F0F_F0F0);
        tick();
        chk("t6_new_done", done, 1);
        chk("t6_new_rows", rows_done, 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
